// File: rtl/apb_pkg.sv
// Shared types and constants for the APB command master and its wait timer.
package apb_pkg;

   localparam int unsigned APB_ADDR_WIDTH = 12;
   localparam int unsigned APB_DATA_WIDTH = 32;
   localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

   localparam logic [2:0] APB_PPROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                      write;
      logic [APB_ADDR_WIDTH-1:0] addr;
      logic [APB_DATA_WIDTH-1:0] wdata;
      logic [APB_STRB_WIDTH-1:0] strb;
   } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with PREADY low; flags the cycle on which the budget runs out.
module apb_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CW     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

   logic [CW-1:0] cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Fires on the stalled cycle that would bring the count up to TIMEOUT_CYCLES.
   assign expire = (TIMEOUT_CYCLES != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 initiator: accepts one valid/ready command, runs SETUP/ACCESS, returns a response.
//
// state  | meaning
// IDLE   | ready for a command (o_cmd_ready high)
// SETUP  | psel=1, penable=0, APB fields loaded
// ACCESS | psel=1, penable=1, waiting on PREADY or timeout
// RESP   | response presented until i_rsp_ready
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic                    i_cmd_write,
   input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_cmd_strb,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_rsp_err,
   output logic                    o_rsp_timeout,
   output logic                    o_psel,
   output logic                    o_penable,
   output logic                    o_pwrite,
   output logic [ADDR_WIDTH-1:0]   o_paddr,
   output logic [DATA_WIDTH-1:0]   o_pwdata,
   output logic [DATA_WIDTH/8-1:0] o_pstrb,
   output logic [2:0]              o_pprot,
   input  logic                    i_pready,
   input  logic                    i_pslverr,
   input  logic [DATA_WIDTH-1:0]   i_prdata
);

   apb_state_e state_q, state_d;
   logic       expire;

   apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .clear   (state_q == SETUP),
      .enable  ((state_q == ACCESS) && !i_pready),
      .expire  (expire)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_cmd_valid)           state_d = SETUP;
         SETUP:                              state_d = ACCESS;
         ACCESS:  if (i_pready || expire)    state_d = RESP;
         RESP:    if (i_rsp_ready)           state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   assign o_cmd_ready = (state_q == IDLE);
   assign o_pprot     = APB_PPROT_DEFAULT;

   // Outputs are registered; APB fields stay put from SETUP through the last ACCESS cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_psel        <= 1'b0;
         o_penable     <= 1'b0;
         o_pwrite      <= 1'b0;
         o_paddr       <= '0;
         o_pwdata      <= '0;
         o_pstrb       <= '0;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= '0;
         o_rsp_err     <= 1'b0;
         o_rsp_timeout <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_cmd_valid) begin
                  o_psel    <= 1'b1;
                  o_penable <= 1'b0;
                  o_pwrite  <= i_cmd_write;
                  o_paddr   <= i_cmd_addr;
                  o_pwdata  <= i_cmd_write ? i_cmd_wdata : '0;
                  o_pstrb   <= i_cmd_write ? i_cmd_strb  : '0;
               end
            end
            SETUP: begin
               o_penable <= 1'b1;
            end
            ACCESS: begin
               if (i_pready) begin
                  o_psel        <= 1'b0;
                  o_penable     <= 1'b0;
                  o_rsp_valid   <= 1'b1;
                  o_rsp_rdata   <= o_pwrite ? '0 : i_prdata;
                  o_rsp_err     <= i_pslverr;
                  o_rsp_timeout <= 1'b0;
               end else if (expire) begin
                  o_psel        <= 1'b0;
                  o_penable     <= 1'b0;
                  o_rsp_valid   <= 1'b1;
                  o_rsp_rdata   <= '0;
                  o_rsp_err     <= 1'b1;
                  o_rsp_timeout <= 1'b1;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid   <= 1'b0;
                  o_rsp_rdata   <= '0;
                  o_rsp_err     <= 1'b0;
                  o_rsp_timeout <= 1'b0;
               end
            end
            default: begin
               o_psel    <= 1'b0;
               o_penable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a hand-driven APB slave; timeout budget set to 8.
module tb_apb_cmd_master;
   import apb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready, pslverr;
   logic [31:0] prdata;

   int n_run  = 0;
   int n_fail = 0;
   int acc, lat;

   always #5 clk = ~clk;

   apb_cmd_master #(
      .ADDR_WIDTH     (12),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_write   (cmd_write),
      .i_cmd_addr    (cmd_addr),
      .i_cmd_wdata   (cmd_wdata),
      .i_cmd_strb    (cmd_strb),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_rdata   (rsp_rdata),
      .o_rsp_err     (rsp_err),
      .o_rsp_timeout (rsp_timeout),
      .o_psel        (psel),
      .o_penable     (penable),
      .o_pwrite      (pwrite),
      .o_paddr       (paddr),
      .o_pwdata      (pwdata),
      .o_pstrb       (pstrb),
      .o_pprot       (pprot),
      .i_pready      (pready),
      .i_pslverr     (pslverr),
      .i_prdata      (prdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issues one command, plays the slave (PREADY after nwait stalled ACCESS cycles),
   // and returns with the response on the bus; acc = ACCESS cycles, lat = cycles from accept.
   task automatic do_xfer(input apb_cmd_t c, input int nwait, input logic [31:0] rd,
                          input logic err, output int n_acc, output int n_lat);
      n_acc = 0;
      n_lat = 0;
      cmd_valid = 1'b1;
      cmd_write = c.write;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      cmd_strb  = c.strb;
      check_eq("accept_ready", {31'd0, cmd_ready}, 32'd1);
      tick;
      cmd_valid = 1'b0;
      n_lat = 1;
      check_eq("setup_psel",    {31'd0, psel},    32'd1);
      check_eq("setup_penable", {31'd0, penable}, 32'd0);
      check_eq("setup_paddr",   {20'd0, paddr},   {20'd0, c.addr});
      check_eq("setup_pwrite",  {31'd0, pwrite},  {31'd0, c.write});
      check_eq("setup_pwdata",  pwdata,           c.write ? c.wdata : 32'd0);
      check_eq("setup_pstrb",   {28'd0, pstrb},   c.write ? {28'd0, c.strb} : 32'd0);
      for (int i = 0; i < 40; i++) begin
         tick;
         n_lat++;
         if (rsp_valid) break;
         if (psel && penable) begin
            n_acc++;
            pready  = (n_acc > nwait);
            pslverr = err;
            prdata  = rd;
            check_eq("access_paddr", {20'd0, paddr}, {20'd0, c.addr});
         end
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'd0;
      check_eq("rsp_seen", {31'd0, rsp_valid}, 32'd1);
   endtask

   task automatic drain;
      rsp_ready = 1'b1;
      tick;
      check_eq("drain_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("drain_ready", {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      rsp_ready = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = '0;

      #2;
      check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("rst_psel",      {31'd0, psel},      32'd0);
      check_eq("rst_penable",   {31'd0, penable},   32'd0);
      check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_eq("rst_paddr",     {20'd0, paddr},     32'd0);
      check_eq("rst_rdata",     rsp_rdata,          32'd0);
      check_eq("rst_pprot",     {29'd0, pprot},     32'd0);
      tick;
      rst_n = 1'b1;
      tick;

      // Zero-wait write
      do_xfer('{write: 1'b1, addr: 12'h004, wdata: 32'hA5A5_0001, strb: 4'hF}, 0, 32'hFFFF_FFFF, 1'b0, acc, lat);
      check_eq("wr_latency",  lat, 32'd3);
      check_eq("wr_access",   acc, 32'd1);
      check_eq("wr_err",      {31'd0, rsp_err},     32'd0);
      check_eq("wr_timeout",  {31'd0, rsp_timeout}, 32'd0);
      check_eq("wr_rdata",    rsp_rdata,            32'd0);
      check_eq("wr_psel_off", {31'd0, psel},        32'd0);
      drain;

      // Read with three wait states
      do_xfer('{write: 1'b0, addr: 12'h008, wdata: 32'h1111_2222, strb: 4'hF}, 3, 32'h0000_1234, 1'b0, acc, lat);
      check_eq("rd_access",  acc, 32'd4);
      check_eq("rd_latency", lat, 32'd6);
      check_eq("rd_rdata",   rsp_rdata,        32'h0000_1234);
      check_eq("rd_err",     {31'd0, rsp_err}, 32'd0);
      drain;

      // Slave error on a write, then a read must drive no strobes
      do_xfer('{write: 1'b1, addr: 12'h010, wdata: 32'h0000_0BAD, strb: 4'h3}, 0, 32'h0, 1'b1, acc, lat);
      check_eq("slverr_err",     {31'd0, rsp_err},     32'd1);
      check_eq("slverr_timeout", {31'd0, rsp_timeout}, 32'd0);
      drain;
      do_xfer('{write: 1'b0, addr: 12'h00C, wdata: 32'h0, strb: 4'h0}, 1, 32'h0000_CAFE, 1'b0, acc, lat);
      check_eq("rd2_access", acc,       32'd2);
      check_eq("rd2_rdata",  rsp_rdata, 32'h0000_CAFE);
      drain;

      // PREADY stuck low: abort after the 8-cycle budget
      do_xfer('{write: 1'b0, addr: 12'h7FC, wdata: 32'h0, strb: 4'h0}, 100, 32'hDEAD_BEEF, 1'b0, acc, lat);
      check_eq("to_access",  acc, 32'd8);
      check_eq("to_latency", lat, 32'd10);
      check_eq("to_err",     {31'd0, rsp_err},     32'd1);
      check_eq("to_timeout", {31'd0, rsp_timeout}, 32'd1);
      check_eq("to_rdata",   rsp_rdata,            32'd0);
      check_eq("to_psel",    {31'd0, psel},        32'd0);
      drain;

      // Response back-pressure with a new command waiting
      rsp_ready = 1'b0;
      do_xfer('{write: 1'b0, addr: 12'h020, wdata: 32'h0, strb: 4'h0}, 0, 32'h0000_55AA, 1'b0, acc, lat);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h030; cmd_wdata = 32'h1234_5678; cmd_strb = 4'hF;
      for (int i = 0; i < 5; i++) begin
         tick;
         check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
         check_eq("bp_rdata", rsp_rdata,          32'h0000_55AA);
         check_eq("bp_ready", {31'd0, cmd_ready}, 32'd0);
         check_eq("bp_psel",  {31'd0, psel},      32'd0);
      end
      cmd_valid = 1'b0;
      drain;

      // Asynchronous reset in the middle of ACCESS
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
      tick;
      cmd_valid = 1'b0;
      tick;
      check_eq("pre_rst_psel",    {31'd0, psel},    32'd1);
      check_eq("pre_rst_penable", {31'd0, penable}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_psel",      {31'd0, psel},      32'd0);
      check_eq("arst_penable",   {31'd0, penable},   32'd0);
      check_eq("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check_eq("post_rst_psel",  {31'd0, psel},      32'd0);
      check_eq("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
      do_xfer('{write: 1'b1, addr: 12'h044, wdata: 32'h0000_00FF, strb: 4'h1}, 0, 32'h0, 1'b0, acc, lat);
      check_eq("post_rst_latency", lat, 32'd3);
      drain;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
